// File: rtl/ntt_ctrl_pkg.sv
// Shared types and default sizing for the NTT stream controller.
package ntt_ctrl_pkg;

    // Default datapath geometry
    localparam int DEF_NUM_STAGES      = 9;
    localparam int DEF_BEATS_PER_FRAME = 32;
    localparam int DEF_STAGE_DELAY     = 40;
    localparam int DEF_MAX_INFLIGHT    = 4;

    // Input-side sequencing states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/ntt_pulse_delay_line.sv
// Shift register carrying accept pulses forward in time; every TAP_SPACING
// positions a tap drives one stage start. Overlapping frames simply occupy
// different bit positions, so their pulses never interact.
module ntt_pulse_delay_line #(
    parameter int DEPTH       = 321,
    parameter int TAPS        = 9,
    parameter int TAP_SPACING = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pulse_in,
    output logic [TAPS-1:0] taps
);

    logic [DEPTH-1:0] shift_reg;

    generate
        if (DEPTH > 1) begin : g_long
            // Shift pulses one position per cycle; reset drops everything pending
            always_ff @(posedge clk) begin
                if (rst) shift_reg <= '0;
                else     shift_reg <= {shift_reg[DEPTH-2:0], pulse_in};
            end
        end else begin : g_short
            // Single-stage case: just one register
            always_ff @(posedge clk) begin
                if (rst) shift_reg <= '0;
                else     shift_reg <= pulse_in;
            end
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            assign taps[gi] = shift_reg[gi*TAP_SPACING];
        end
    endgenerate

endmodule

// File: rtl/ntt_stream_ctrl.sv
// Frame-level sequencer for the pipelined NTT: loads frames at one beat per
// cycle, fires per-stage start pulses, frames the result stream off the final
// stage's output-start pulse and tracks frames in flight.
module ntt_stream_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int BEATS_PER_FRAME = DEF_BEATS_PER_FRAME,
    parameter int STAGE_DELAY     = DEF_STAGE_DELAY,
    parameter int MAX_INFLIGHT    = DEF_MAX_INFLIGHT,
    localparam int IDX_W          = $clog2(BEATS_PER_FRAME),
    localparam int CNT_W          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  beat_en,
    output logic [IDX_W-1:0]      beat_idx,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] out_start,
    output logic                  out_valid,
    output logic [IDX_W-1:0]      out_beat_idx,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      inflight,
    output logic                  err_underrun,
    output logic                  err_overlap
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);
    localparam int               DL_DEPTH  = (NUM_STAGES - 1) * STAGE_DELAY + 1;

    ctrl_state_t      state_reg, state_next;
    logic [IDX_W-1:0] beat_idx_reg, beat_idx_next;
    logic [IDX_W-1:0] out_idx_reg;
    logic             res_active_reg;
    logic [CNT_W-1:0] inflight_reg;
    logic             err_underrun_reg;
    logic             err_overlap_reg;

    logic on_last_beat;
    logic accept;
    logic last_stage_pulse;
    logic frame_done_int;
    logic underflow_done;

    // Only the final stage's output-start is meaningful to this block
    generate
        if (NUM_STAGES > 1) begin : g_unused
            logic unused_out_start;
            assign unused_out_start = ^out_start[NUM_STAGES-2:0];
        end
    endgenerate

    assign on_last_beat     = (state_reg == LOAD) && (beat_idx_reg == LAST_BEAT);
    // Decoded from registers only; the rst term keeps it low while in reset
    assign req_ready        = !rst && ((state_reg == IDLE) || on_last_beat)
                              && (inflight_reg < MAX_CNT);
    assign accept           = req_valid && req_ready;
    assign last_stage_pulse = out_start[NUM_STAGES-1];
    assign frame_done_int   = res_active_reg && (out_idx_reg == LAST_BEAT);
    assign underflow_done   = frame_done_int && !accept && (inflight_reg == '0);

    // State and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            beat_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            beat_idx_reg <= beat_idx_next;
        end
    end

    // Next-state: a load never stalls; the last beat either chains a new frame or idles
    always_comb begin
        state_next    = state_reg;
        beat_idx_next = beat_idx_reg;
        case (state_reg)
            IDLE: begin
                beat_idx_next = '0;
                if (accept) state_next = LOAD;
            end
            LOAD: begin
                if (beat_idx_reg == LAST_BEAT) begin
                    beat_idx_next = '0;
                    state_next    = accept ? LOAD : IDLE;
                end else begin
                    beat_idx_next = beat_idx_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                beat_idx_next = '0;
            end
        endcase
    end

    // Stage start pulses: the accept pulse enters the line, taps land on beat 0 onward
    ntt_pulse_delay_line #(
        .DEPTH       (DL_DEPTH),
        .TAPS        (NUM_STAGES),
        .TAP_SPACING (STAGE_DELAY)
    ) u_delay_line (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (accept),
        .taps     (stage_start)
    );

    // Result framing: a final-stage pulse (re)starts a BEATS_PER_FRAME-long window
    always_ff @(posedge clk) begin
        if (rst) begin
            res_active_reg <= 1'b0;
            out_idx_reg    <= '0;
        end else if (last_stage_pulse) begin
            res_active_reg <= 1'b1;
            out_idx_reg    <= '0;
        end else if (res_active_reg) begin
            if (out_idx_reg == LAST_BEAT) begin
                res_active_reg <= 1'b0;
                out_idx_reg    <= '0;
            end else begin
                out_idx_reg <= out_idx_reg + IDX_W'(1);
            end
        end
    end

    // In-flight count: accept adds, completion removes, never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (accept && !frame_done_int) begin
            inflight_reg <= inflight_reg + CNT_W'(1);
        end else if (frame_done_int && !accept && (inflight_reg != '0)) begin
            inflight_reg <= inflight_reg - CNT_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underrun_reg <= 1'b0;
            err_overlap_reg  <= 1'b0;
        end else begin
            if ((state_reg == LOAD) && !in_valid)
                err_underrun_reg <= 1'b1;
            if ((last_stage_pulse && res_active_reg) || underflow_done)
                err_overlap_reg <= 1'b1;
        end
    end

    assign in_ready     = (state_reg == LOAD);
    assign beat_en      = (state_reg == LOAD);
    assign beat_idx     = beat_idx_reg;
    assign out_valid    = res_active_reg;
    assign out_beat_idx = out_idx_reg;
    assign frame_done   = frame_done_int;
    assign inflight     = inflight_reg;
    assign err_underrun = err_underrun_reg;
    assign err_overlap  = err_overlap_reg;

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Directed bench for ntt_stream_ctrl with the default geometry.
module tb_ntt_stream_ctrl;

    localparam int NS    = 9;
    localparam int BPF   = 32;
    localparam int SD    = 40;
    localparam int MI    = 4;
    localparam int IDX_W = 5;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             in_valid;
    logic             in_ready;
    logic             beat_en;
    logic [IDX_W-1:0] beat_idx;
    logic [NS-1:0]    stage_start;
    logic [NS-1:0]    out_start;
    logic             out_valid;
    logic [IDX_W-1:0] out_beat_idx;
    logic             frame_done;
    logic [CNT_W-1:0] inflight;
    logic             err_underrun;
    logic             err_overlap;

    int total = 0;
    int bad   = 0;

    ntt_stream_ctrl #(
        .NUM_STAGES      (NS),
        .BEATS_PER_FRAME (BPF),
        .STAGE_DELAY     (SD),
        .MAX_INFLIGHT    (MI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .beat_en      (beat_en),
        .beat_idx     (beat_idx),
        .stage_start  (stage_start),
        .out_start    (out_start),
        .out_valid    (out_valid),
        .out_beat_idx (out_beat_idx),
        .frame_done   (frame_done),
        .inflight     (inflight),
        .err_underrun (err_underrun),
        .err_overlap  (err_overlap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stage_start vector o cycles after stage 0 fired
    function automatic logic [NS-1:0] stage_exp(input int o);
        if (o >= 0 && (o % SD) == 0 && (o / SD) < NS) return NS'(1) << (o / SD);
        return '0;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_beat_en"}, beat_en, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_beat_idx"}, beat_idx, 0);
        chk({tag, "_stage"}, stage_start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_beat_idx, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_inflight"}, inflight, 0);
        chk({tag, "_err_under"}, err_underrun, 0);
        chk({tag, "_err_ovl"}, err_overlap, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int fd_cnt;
        logic [NS-1:0] seen;
        rst = 1'b1; req_valid = 1'b0; in_valid = 1'b1; out_start = '0;

        // ---- reset state ----
        repeat (3) tick();
        chk("por_req_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        #1;
        chk("por_req_ready", req_ready, 1);
        check_idle_zero("por");
        $display("reset: released");

        // ---- single frame, underrun on beat 5 ----
        req_valid = 1'b1;
        chk("sf_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        for (int o = 0; o <= 330; o++) begin
            in_valid = (o == 5) ? 1'b0 : 1'b1;
            chk($sformatf("sf_beat_en_%0d", o), beat_en, (o < BPF) ? 1 : 0);
            chk($sformatf("sf_in_ready_%0d", o), in_ready, (o < BPF) ? 1 : 0);
            chk($sformatf("sf_beat_idx_%0d", o), beat_idx, (o < BPF) ? o : 0);
            chk($sformatf("sf_stage_%0d", o), stage_start, stage_exp(o));
            chk($sformatf("sf_inflight_%0d", o), inflight, 1);
            chk($sformatf("sf_underrun_%0d", o), err_underrun, (o >= 6) ? 1 : 0);
            tick();
        end
        in_valid = 1'b1;
        $display("frame: single frame loaded, underrun on beat 5");

        // ---- result framing with simultaneous accept on frame_done ----
        out_start = 9'h100;
        chk("rf_out_valid_pre", out_valid, 0);
        tick();
        out_start = '0;
        for (int j = 1; j <= BPF; j++) begin
            chk($sformatf("rf_out_valid_%0d", j), out_valid, 1);
            chk($sformatf("rf_out_idx_%0d", j), out_beat_idx, j - 1);
            chk($sformatf("rf_done_%0d", j), frame_done, (j == BPF) ? 1 : 0);
            chk($sformatf("rf_inflight_%0d", j), inflight, 1);
            if (j == BPF) begin
                req_valid = 1'b1;
                chk("rf_req_ready_at_done", req_ready, 1);
            end
            tick();
        end
        req_valid = 1'b0;
        chk("rf_out_valid_post", out_valid, 0);
        chk("rf_done_post", frame_done, 0);
        chk("rf_inflight_same", inflight, 1);
        chk("rf_beat_en", beat_en, 1);
        chk("rf_beat_idx0", beat_idx, 0);
        chk("rf_stage0", stage_start, 9'h001);
        $display("result: frame done with simultaneous accept");
        repeat (BPF) tick();
        chk("rf_load_over", beat_en, 0);

        // ---- plain completion decrements inflight ----
        out_start = 9'h100;
        tick();
        out_start = '0;
        repeat (BPF - 1) tick();
        chk("dec_done", frame_done, 1);
        chk("dec_inflight_pre", inflight, 1);
        tick();
        chk("dec_inflight", inflight, 0);
        chk("dec_err_ovl", err_overlap, 0);
        chk("dec_underrun_sticky", err_underrun, 1);
        $display("result: frame done, inflight back to 0");

        // ---- reset mid-frame ----
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (15) tick();
        chk("mr_beat15", beat_idx, 15);
        do_reset();
        check_idle_zero("mr");
        seen = '0;
        for (int o = 0; o < 340; o++) begin
            seen = seen | stage_start;
            tick();
        end
        chk("mr_no_pulses", seen, 0);
        req_valid = 1'b1;
        chk("mr_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("mr_beat_en", beat_en, 1);
        chk("mr_beat_idx", beat_idx, 0);
        chk("mr_stage0", stage_start, 9'h001);
        chk("mr_inflight", inflight, 1);
        for (int o = 1; o <= SD; o++) begin
            tick();
            chk($sformatf("mr_stage_%0d", o), stage_start, stage_exp(o));
        end
        $display("reset: mid-frame reset recovered");

        // ---- back-to-back frames up to MAX_INFLIGHT ----
        do_reset();
        req_valid = 1'b1;
        chk("bb_req_ready", req_ready, 1);
        tick();
        for (int o = 0; o < 136; o++) begin
            chk($sformatf("bb_beat_en_%0d", o), beat_en, (o < 4*BPF) ? 1 : 0);
            chk($sformatf("bb_beat_idx_%0d", o), beat_idx, (o < 4*BPF) ? (o % BPF) : 0);
            chk($sformatf("bb_inflight_%0d", o), inflight, (o / BPF + 1 > MI) ? MI : (o / BPF + 1));
            chk($sformatf("bb_stage0_%0d", o), stage_start[0],
                (o < 4*BPF && (o % BPF) == 0) ? 1 : 0);
            chk($sformatf("bb_req_ready_%0d", o), req_ready,
                ((o % BPF) == BPF - 1 && o < 3*BPF) ? 1 : 0);
            tick();
        end
        req_valid = 1'b0;
        $display("frame: four back-to-back frames, fifth held");

        // ---- overlap: second final-stage pulse during result beat 10 ----
        out_start = 9'h100;
        tick();
        out_start = '0;
        for (int j = 1; j <= 11; j++) begin
            chk($sformatf("ov_out_idx_%0d", j), out_beat_idx, j - 1);
            if (j == 11) begin
                out_start = 9'h100;
                chk("ov_err_pre", err_overlap, 0);
            end
            tick();
        end
        out_start = '0;
        chk("ov_err", err_overlap, 1);
        chk("ov_restart_idx", out_beat_idx, 0);
        chk("ov_out_valid", out_valid, 1);
        chk("ov_inflight_pre", inflight, 4);
        fd_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (frame_done) fd_cnt++;
            tick();
        end
        chk("ov_frame_done_count", fd_cnt, 1);
        chk("ov_inflight", inflight, 3);
        chk("ov_err_sticky", err_overlap, 1);
        $display("result: overlap detected, one frame_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
